// File: rtl/nd_tile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nd_tile_pkg : shared types and defaults for the tile assembler        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package nd_tile_pkg;

  localparam int DEF_ROWS = 6;
  localparam int DEF_COLS = 4;
  localparam int DEF_W    = 3;

  typedef logic [DEF_W-1:0] elem_t;
  typedef elem_t            row_t  [DEF_COLS];
  typedef row_t             tile_t [DEF_ROWS];

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } bank_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nd_tile_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nd_tile_bank : one ROWS x COLS tile store with a row-wide write port  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module nd_tile_bank
  import nd_tile_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int W    = DEF_W,
  parameter int RW   = idx_width(ROWS)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [W-1:0]  wdata [COLS],
  output logic [W-1:0]  tile  [ROWS][COLS]
);

  // Data storage is intentionally left without reset.
  logic [W-1:0] mem [ROWS][COLS];

  always_ff @(posedge CLK) begin
    if (we) begin
      for (int c = 0; c < COLS; c++) begin
        mem[waddr][c] <= wdata[c];
      end
    end
  end

  assign tile = mem;

endmodule
`default_nettype wire

// File: rtl/nd_tile_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nd_tile_assembler : gathers ROWS input rows into a complete tile.     |
// | Define ND_TILE_PINGPONG_EN for two-bank double buffering.             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module nd_tile_assembler
  import nd_tile_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int W    = DEF_W
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sof,
  input  logic [W-1:0] in_row   [COLS],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_tile [ROWS][COLS],
  output logic         err
);

  localparam int RW = idx_width(ROWS);
`ifdef ND_TILE_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam logic SWAP = (NBANK == 2);

  bank_state_e   state_q [2];
  bank_state_e   state_d [2];
  logic [RW-1:0] wcnt_q, wcnt_d, widx;
  logic          wsel_q, wsel_d, rsel_q, rsel_d;
  logic          ready_q, ready_d, err_q, err_d;
  logic          accept, consume, last;
  logic [W-1:0]  bank_tile [NBANK][ROWS][COLS];

  assign in_ready  = ready_q;
  assign out_valid = (state_q[rsel_q] == FULL);
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    accept  = in_valid && ready_q;
    consume = out_valid && out_ready;
    // A start-of-frame always lands in row 0, discarding any partial tile.
    widx    = in_sof ? '0 : wcnt_q;
    last    = (widx == RW'(ROWS - 1));
    err_d   = accept && in_sof && (wcnt_q != '0);
    if (accept) begin
      wcnt_d = last ? '0 : widx + RW'(1);
      if (last) begin
        state_d[wsel_q] = FULL;
        wsel_d          = wsel_q ^ SWAP;
      end
    end
    if (consume) begin
      state_d[rsel_q] = FILL;
      rsel_d          = rsel_q ^ SWAP;
    end
    ready_d = (state_d[wsel_d] == FILL);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q[0] <= FILL;
      state_q[1] <= FILL;
      wcnt_q     <= '0;
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      wcnt_q     <= wcnt_d;
      wsel_q     <= wsel_d;
      rsel_q     <= rsel_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  genvar b;
  generate
    for (b = 0; b < NBANK; b++) begin : g_bank
      nd_tile_bank #(
        .ROWS (ROWS),
        .COLS (COLS),
        .W    (W),
        .RW   (RW)
      ) u_bank (
        .CLK   (CLK),
        .we    (accept && (wsel_q == 1'(b))),
        .waddr (widx),
        .wdata (in_row),
        .tile  (bank_tile[b])
      );
    end
    if (NBANK == 2) begin : g_pp_mux
      assign out_tile = rsel_q ? bank_tile[1] : bank_tile[0];
    end else begin : g_single_mux
      assign out_tile = bank_tile[0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_nd_tile_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nd_tile_assembler : randomized bench with a tile-queue model       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_nd_tile_assembler;

  localparam int ROWS = 6;
  localparam int COLS = 4;
  localparam int W    = 3;
  localparam int RB   = COLS * W;
`ifdef ND_TILE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_sof = 1'b0;
  logic [W-1:0] in_row [COLS];
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_tile [ROWS][COLS];
  logic         err;

  nd_tile_assembler #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tile  (out_tile),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: completed tiles in arrival order plus the partial tile.
  logic [127:0] q[$];
  logic [127:0] partv = '0;
  int           pcnt = 0;
  int           tiles_in = 0;
  int           tiles_out = 0;
  bit           err_exp = 0;
  bit           hold = 0;
  logic [127:0] prev_tile = '0;
  bit           accepted = 0;

  function automatic logic [127:0] pack_out();
    logic [127:0] p = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        p[(r*COLS+c)*W +: W] = out_tile[r][c];
    return p;
  endfunction

  task automatic model_accept(input bit s, input logic [RB-1:0] rowv);
    if (s && pcnt != 0) err_exp = 1;
    if (s) pcnt = 0;
    partv[pcnt*RB +: RB] = rowv;
    pcnt++;
    if (pcnt == ROWS) begin
      q.push_back(partv);
      tiles_in++;
      pcnt = 0;
    end
  endtask

  task automatic step(input bit r, input bit v, input bit s, input bit ordy,
                      input logic [RB-1:0] rowv);
    @(posedge CLK);
    #1;
    if (RESET) begin
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_err", 128'(err), 128'(0));
    end else begin
      check("err", 128'(err), 128'(err_exp));
      check("out_valid", 128'(out_valid), 128'(q.size() > 0));
      check("in_ready", 128'(in_ready), 128'(q.size() < NB));
      if (hold) check("hold_tile", pack_out(), prev_tile);
    end
    err_exp   = 0;
    RESET     = r;
    in_valid  = v;
    in_sof    = s;
    out_ready = ordy;
    for (int c = 0; c < COLS; c++) in_row[c] = rowv[c*W +: W];
    accepted = 0;
    if (r) begin
      q.delete();
      pcnt = 0;
      hold = 0;
    end else begin
      hold      = out_valid && !out_ready;
      prev_tile = pack_out();
      if (out_valid && out_ready && q.size() > 0) begin
        check("tile", pack_out(), q.pop_front());
        tiles_out++;
      end
      if (in_valid && in_ready) begin
        model_accept(s, rowv);
        accepted = 1;
      end
    end
  endtask

  task automatic send_row(input logic [RB-1:0] rowv, input bit s, input bit ordy,
                          output int tries);
    tries = 0;
    do begin
      step(0, 1, s, ordy, rowv);
      tries++;
    end while (!accepted && tries < 50);
    if (!accepted) check("send_timeout", 128'(accepted), 128'(1));
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, 0, 0, ordy, '0);
  endtask

  function automatic logic [RB-1:0] ramp_row(input int r);
    logic [RB-1:0] v = '0;
    for (int c = 0; c < COLS; c++) v[c*W +: W] = W'(r*4 + c);
    return v;
  endfunction

  int tries, total, cyc, target;
  bit s;

  initial begin
    for (int c = 0; c < COLS; c++) in_row[c] = '0;
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(0, 0, 0, 1, '0);

    // Ramp tile, always-ready consumer.
    for (int r = 0; r < ROWS; r++) send_row(ramp_row(r), r == 0, 1, tries);
    step(0, 0, 0, 1, '0);
    check("t1_valid", 128'(out_valid), 128'(1));
    check("t1_elem23", 128'(out_tile[2][3]), 128'(3));
    step(0, 0, 0, 1, '0);
    check("t1_single", 128'(out_valid), 128'(0));

    // Stalled consumer with continued input pressure.
    for (int r = 0; r < ROWS; r++) send_row(RB'($urandom), r == 0, 0, tries);
    for (int i = 0; i < 10; i++) step(0, 1, pcnt == 0, 0, RB'($urandom));
    idle(20, 1);

    // Mid-tile resync.
    for (int r = 0; r < 3; r++) send_row(RB'($urandom), r == 0, 1, tries);
    send_row({COLS{3'd7}}, 1, 1, tries);
    for (int r = 0; r < 5; r++) send_row(RB'($urandom), 0, 0, tries);
    for (int i = 0; i < 10 && !out_valid; i++) step(0, 0, 0, 0, '0);
    check("t3_valid", 128'(out_valid), 128'(1));
    if (out_valid) check("t3_row0", pack_out() & 128'({RB{1'b1}}), 128'({COLS{3'd7}}));
    idle(10, 1);

    // Reset mid-tile, then a fresh tile.
    for (int r = 0; r < 4; r++) send_row(RB'($urandom), r == 0, 1, tries);
    step(1, 0, 0, 1, '0);
    step(1, 0, 0, 1, '0);
    step(0, 0, 0, 1, '0);
    for (int r = 0; r < ROWS; r++) send_row(ramp_row(r + 1), r == 0, 1, tries);
    idle(4, 1);

`ifdef ND_TILE_PINGPONG_EN
    // Sustained throughput: every row accepted on its first offer.
    total = 0;
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < ROWS; r++) begin
        send_row(RB'($urandom), r == 0, 1, tries);
        total += tries;
      end
    check("t5_cycles", 128'(total), 128'(4 * ROWS));
    idle(4, 1);
`endif

    // Random stalls over 100 tiles.
    target = tiles_out + 100;
    cyc = 0;
    while (tiles_out < target && cyc < 20000) begin
      s = (pcnt == 0) ? bit'($urandom % 2) : ($urandom % 25 == 0);
      step(0, ($urandom % 4) != 0, s, ($urandom % 3) != 0, RB'($urandom));
      cyc++;
    end
    check("t6_budget", 128'(cyc < 20000), 128'(1));
    step(0, 0, 0, 1, '0);
    idle(8, 1);
    check("t6_no_loss", 128'(tiles_out), 128'(tiles_in));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nd_tile_assembler.md
ND_TILE_ASSEMBLER -- requirements
Module: nd_tile_assembler

Interface
REQ-001 Parameter ROWS, default 6, tile rows (outer index).
REQ-002 Parameter COLS, default 4, elements per row (middle index).
REQ-003 Parameter W, default 3, element bit width.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream row valid.
REQ-007 in_ready  output  1  block accepts a row this cycle.
REQ-008 in_sof  input  1  row is row 0 of a new tile.
REQ-009 in_row  input  [W-1:0] x [COLS-1:0] unpacked  one row of elements.
REQ-010 out_valid  output  1  complete tile presented.
REQ-011 out_ready  input  1  downstream consumes tile.
REQ-012 out_tile  output  [W-1:0] x [ROWS-1:0][COLS-1:0] unpacked  assembled tile; out_tile[r][c] = element c of the r-th accepted row.
REQ-013 err  output  1  one-cycle pulse on framing resync.

Function
REQ-014 Row accepted iff in_valid && in_ready on a rising edge.
REQ-015 Row counter wcnt (0..ROWS-1) selects destination row; increments per accepted row, wraps ROWS-1 -> 0.
REQ-016 States per bank: FILL (wcnt counting, bank not full) and FULL (bank holds complete tile awaiting consumer).
REQ-017 FILL -> FULL when row ROWS-1 accepted; out_valid asserts the next cycle (latency 1 cycle from last-row acceptance).
REQ-018 FULL -> FILL on out_valid && out_ready; out_valid deasserts next cycle unless another bank is FULL.
REQ-019 out_tile and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-020 in_ready SHALL be a registered function of bank state only, never combinationally dependent on out_ready or in_valid.
REQ-021 in_sof accepted with wcnt != 0: partial tile discarded, row written to row 0, wcnt becomes 1, err pulses high the following cycle.
REQ-022 in_sof low with wcnt == 0: row accepted as row 0 without error (sof advisory at tile start).
REQ-023 ROWS == 1: every accepted row completes a tile.
REQ-024 out_tile contents when out_valid low are don't-care; bench SHALL not check them.

Reset
REQ-025 RESET high: wcnt=0, all banks FILL, out_valid=0, err=0, in_ready=0 during reset cycle, in_ready=1 first cycle after RESET deasserts.
REQ-026 RESET mid-tile or with a FULL tile pending discards all data; no tile emitted for pre-reset rows.
REQ-027 Tile storage SHALL not be reset (data registers unreset).

Configuration
REQ-028 Macro ND_TILE_PINGPONG_EN defined: two banks; write bank fills while read bank is FULL; banks swap roles on completion; in_ready=0 only when both banks FULL; back-to-back tiles with out_ready=1 sustain one row per cycle.
REQ-029 ND_TILE_PINGPONG_EN undefined: one bank; in_ready=0 whenever bank FULL; one idle input cycle minimum between tiles.
REQ-030 Tile order out SHALL equal tile order in under both configurations.

Structure
REQ-031 Shared package nd_tile_pkg: default ROWS/COLS/W localparams, element typedef logic [W-1:0], row and tile unpacked-array typedefs, bank-state enum {FILL, FULL}.
REQ-032 One sub-module nd_tile_bank: single ROWS x COLS storage plus write port indexed by row; instantiated once or twice per configuration.

Verification
REQ-033 Reset, then 6 rows with element value r*4+c, sof on row 0, out_ready=1 -> out_valid one cycle after row 5, out_tile[2][3]=3'd3 (11 mod 8), single cycle valid.
REQ-034 Tile complete, out_ready=0 for 10 cycles -> out_tile and out_valid stable; single-bank in_ready=0 throughout; pingpong accepts next 6 rows then in_ready=0.
REQ-035 3 rows accepted, then sof row with value 7 -> err pulse next cycle; after 5 more rows tile row 0 all 3'd7.
REQ-036 RESET asserted after 4 rows -> no out_valid; fresh 6-row tile emits correctly afterwards.
REQ-037 Pingpong, in_valid=1 and out_ready=1 continuously for 4 tiles -> 24 rows in 24 cycles, 4 tiles out in order, in_ready never low.
REQ-038 Random in_valid/out_ready stalls, 100 tiles -> scoreboard match, no loss or duplication.
